hazard_control_unit: RTL and testbench

- Central hazard controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). Generalises the per-operand forwarding units to NUM_SRC operands.
- Adds the following behaviour the current pipeline lacks:
  - load-use stall detection
  - taken-branch flush
  - whole-pipeline freeze for a multi-cycle data memory of MEM_LATENCY cycles
  - saturating stall and flush performance counters
- Drives the write-enable and flush inputs of every barrier register.

---
 rtl/hazard_control_unit_if.sv | 80 ++++++++
 rtl/hazard_control_unit.sv | 212 +++++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_if
//
// Purpose:
//   Bundles every pipeline-facing signal of the hazard control unit. The
//   pipeline datapath is the master. It drives the register indices and
//   stage status. The hazard unit is the slave. It returns forwarding
//   selects, barrier-register enables/flushes and the performance counters.
//
// Signal summary (directions seen from the slave / hazard unit):
//   in  id_src_idx      NUM_SRC*REG_IDX_W  ID source indices, operand k at [k*REG_IDX_W +: REG_IDX_W]
//   in  id_src_used     NUM_SRC            operand k is really read in ID
//   in  ex_src_idx      NUM_SRC*REG_IDX_W  EX source indices, same packing
//   in  ex_rd           REG_IDX_W          EX destination
//   in  ex_mem_read     1                  EX instruction is a load
//   in  ex_branch_taken 1                  branch/jump resolved taken in EX
//   in  mem_rd          REG_IDX_W          MEM destination
//   in  mem_reg_write   1                  MEM writes a register
//   in  mem_access      1                  MEM instruction touches data memory
//   in  wb_rd           REG_IDX_W          WB destination
//   in  wb_reg_write    1                  WB writes a register
//   out fwd_sel         2*NUM_SRC          per EX operand: 00 reg, 01 WB data, 10 MEM ALU result
//   out pc_write_en     1                  PC update enable
//   out if_id_write_en  1                  IF/ID barrier enable
//   out if_id_flush     1                  IF/ID loads NOP
//   out id_ex_write_en  1                  ID/EX barrier enable
//   out id_ex_flush     1                  ID/EX loads bubble
//   out ex_mem_write_en 1                  EX/MEM barrier enable
//   out mem_wb_bubble   1                  MEM/WB loads bubble
//   out stall_cycles    CNT_W              cycles with pc_write_en=0 since reset
//   out flush_count     CNT_W              taken-branch flushes since reset
// ---------------------------------------------------------------------------
interface hazard_control_unit_if #(
    parameter int NUM_SRC   = 2,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32
);
    logic [NUM_SRC*REG_IDX_W-1:0] id_src_idx;
    logic [NUM_SRC-1:0]           id_src_used;
    logic [NUM_SRC*REG_IDX_W-1:0] ex_src_idx;
    logic [REG_IDX_W-1:0]         ex_rd;
    logic                         ex_mem_read;
    logic                         ex_branch_taken;
    logic [REG_IDX_W-1:0]         mem_rd;
    logic                         mem_reg_write;
    logic                         mem_access;
    logic [REG_IDX_W-1:0]         wb_rd;
    logic                         wb_reg_write;

    logic [2*NUM_SRC-1:0]         fwd_sel;
    logic                         pc_write_en;
    logic                         if_id_write_en;
    logic                         if_id_flush;
    logic                         id_ex_write_en;
    logic                         id_ex_flush;
    logic                         ex_mem_write_en;
    logic                         mem_wb_bubble;
    logic [CNT_W-1:0]             stall_cycles;
    logic [CNT_W-1:0]             flush_count;

    // Pipeline datapath side
    modport master (
        output id_src_idx, id_src_used, ex_src_idx, ex_rd, ex_mem_read,
               ex_branch_taken, mem_rd, mem_reg_write, mem_access,
               wb_rd, wb_reg_write,
        input  fwd_sel, pc_write_en, if_id_write_en, if_id_flush,
               id_ex_write_en, id_ex_flush, ex_mem_write_en, mem_wb_bubble,
               stall_cycles, flush_count
    );

    // Hazard control unit side
    modport slave (
        input  id_src_idx, id_src_used, ex_src_idx, ex_rd, ex_mem_read,
               ex_branch_taken, mem_rd, mem_reg_write, mem_access,
               wb_rd, wb_reg_write,
        output fwd_sel, pc_write_en, if_id_write_en, if_id_flush,
               id_ex_write_en, id_ex_flush, ex_mem_write_en, mem_wb_bubble,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Purpose:
//   Central hazard controller for the 5-stage RISC-V pipeline. It provides:
//     - operand forwarding for NUM_SRC EX operands (MEM beats WB),
//     - one-cycle load-use stall detection,
//     - taken-branch flush of IF/ID and ID/EX,
//     - a whole-pipeline freeze of MEM_LATENCY cycles per data-memory access,
//     - saturating stall-cycle and flush performance counters.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of hazard_control_unit_if (see that file for signals)
//
// Parameters:
//   NUM_SRC      source operands per instruction (1..4)
//   REG_IDX_W    register index width
//   MEM_LATENCY  extra frozen cycles per data-memory access (0..15, 0 = none)
//   CNT_W        performance counter width
// ---------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int NUM_SRC     = 2,
    parameter int REG_IDX_W   = 5,
    parameter int MEM_LATENCY = 0,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_control_unit_if.slave  bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // The first frozen cycle happens in RUN, so WAIT only needs to count the
    // remaining MEM_LATENCY-1 frozen cycles before its release cycle.
    localparam int             LAT_INIT  = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
    localparam logic [3:0]     WAIT_INIT = 4'(LAT_INIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q;
    logic [3:0]         wait_cnt_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_d;

    logic               freeze;
    logic               load_use;
    logic [2*NUM_SRC-1:0] fwd_sel_c;
    logic               pc_we_c;
    logic               if_id_we_c;
    logic               if_id_flush_c;
    logic               id_ex_we_c;
    logic               id_ex_flush_c;
    logic               ex_mem_we_c;
    logic               mem_wb_bubble_c;

    // Freeze is asserted combinationally. An access entering MEM freezes the
    // pipeline in the same cycle it shows up, before the FSM has left RUN.
    always_comb begin
        freeze = 1'b0;
        if (MEM_LATENCY > 0) begin
            if (state_q == ST_RUN) begin
                freeze = bus.mem_access;
            end else begin
                freeze = (wait_cnt_q != 4'd0);
            end
        end
    end

    // Freeze FSM. WAIT with a zero counter is the release cycle. The access
    // advances on that edge and the FSM goes back to RUN, where an access
    // that follows straight after starts a fresh freeze.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if ((MEM_LATENCY > 0) && bus.mem_access) begin
                        state_q    <= ST_WAIT;
                        wait_cnt_q <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q != 4'd0) begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    wait_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    // Load-use hazard: the load in EX produces a register that the ID
    // instruction really reads. Register x0 never creates a dependency.
    always_comb begin
        load_use = 1'b0;
        if (bus.ex_mem_read && (bus.ex_rd != '0)) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (bus.id_src_used[k] &&
                    (bus.id_src_idx[k*REG_IDX_W +: REG_IDX_W] == bus.ex_rd)) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // Forwarding stays active during a freeze because the EX operands must
    // remain correct while the instruction waits. The younger MEM result
    // wins over WB.
    always_comb begin
        fwd_sel_c = '0;
        if (!reset) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (bus.ex_src_idx[k*REG_IDX_W +: REG_IDX_W] == '0) begin
                    fwd_sel_c[2*k +: 2] = 2'b00;
                end else if (bus.mem_reg_write &&
                             (bus.mem_rd == bus.ex_src_idx[k*REG_IDX_W +: REG_IDX_W])) begin
                    fwd_sel_c[2*k +: 2] = 2'b10;
                end else if (bus.wb_reg_write &&
                             (bus.wb_rd == bus.ex_src_idx[k*REG_IDX_W +: REG_IDX_W])) begin
                    fwd_sel_c[2*k +: 2] = 2'b01;
                end else begin
                    fwd_sel_c[2*k +: 2] = 2'b00;
                end
            end
        end
    end

    // Barrier-register control, in priority order: freeze, taken branch,
    // load-use, normal flow. A taken branch squashes the ID instruction, so
    // any load-use hazard it had is irrelevant. During a freeze, branch and
    // load-use are deferred to the release cycle because EX is not moving.
    always_comb begin
        pc_we_c         = 1'b0;
        if_id_we_c      = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_we_c      = 1'b0;
        id_ex_flush_c   = 1'b0;
        ex_mem_we_c     = 1'b0;
        mem_wb_bubble_c = 1'b0;
        if (!reset) begin
            if (freeze) begin
                mem_wb_bubble_c = 1'b1;
            end else if (bus.ex_branch_taken) begin
                pc_we_c       = 1'b1;
                if_id_we_c    = 1'b1;
                if_id_flush_c = 1'b1;
                id_ex_we_c    = 1'b1;
                id_ex_flush_c = 1'b1;
                ex_mem_we_c   = 1'b1;
            end else if (load_use) begin
                id_ex_we_c    = 1'b1;
                id_ex_flush_c = 1'b1;
                ex_mem_we_c   = 1'b1;
            end else begin
                pc_we_c     = 1'b1;
                if_id_we_c  = 1'b1;
                id_ex_we_c  = 1'b1;
                ex_mem_we_c = 1'b1;
            end
        end
    end

    // Next values for the performance counters. Both counters stop at
    // all-ones so a long run cannot wrap them back to small values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_we_c && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (bus.ex_branch_taken && !freeze && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.fwd_sel         = fwd_sel_c;
    assign bus.pc_write_en     = pc_we_c;
    assign bus.if_id_write_en  = if_id_we_c;
    assign bus.if_id_flush     = if_id_flush_c;
    assign bus.id_ex_write_en  = id_ex_we_c;
    assign bus.id_ex_flush     = id_ex_flush_c;
    assign bus.ex_mem_write_en = ex_mem_we_c;
    assign bus.mem_wb_bubble   = mem_wb_bubble_c;
    assign bus.stall_cycles    = stall_cnt_q;
    assign bus.flush_count     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Purpose:
//   Testbench for hazard_control_unit with NUM_SRC=2, MEM_LATENCY=3 and
//   CNT_W=4. A stimulus process drives one input vector per cycle. It
//   computes the expected response from a behavioural model of the hazard
//   rules and pushes that response into a scoreboard queue. A separate
//   monitor pops the queue on each falling edge and compares it against the
//   outputs the design presents.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam int NUM_SRC   = 2;
    localparam int REG_IDX_W = 5;
    localparam int LAT       = 3;
    localparam int CNT_W     = 4;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic [9:0] id_src_idx;
        logic [1:0] id_src_used;
        logic [9:0] ex_src_idx;
        logic [4:0] ex_rd;
        logic       ex_mem_read;
        logic       br;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic       mem_acc;
        logic [4:0] wb_rd;
        logic       wb_rw;
    } stim_t;

    // ctrl = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble}
    typedef struct packed {
        int         cycle;
        logic [3:0] fwd;
        logic [6:0] ctrl;
        logic [3:0] stall;
        logic [3:0] flush;
    } expect_t;

    logic clk;
    logic reset;

    hazard_control_unit_if #(
        .NUM_SRC  (NUM_SRC),
        .REG_IDX_W(REG_IDX_W),
        .CNT_W    (CNT_W)
    ) bus ();

    hazard_control_unit #(
        .NUM_SRC    (NUM_SRC),
        .REG_IDX_W  (REG_IDX_W),
        .MEM_LATENCY(LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    expect_t sbQ[$];
    int      testsRun    = 0;
    int      testsFailed = 0;
    int      cycleNum    = 0;

    // Reference-model state: the age of the access now held in MEM (-1 when
    // there is none), plus the event totals kept as plain integers.
    int      accessAge   = -1;
    int      stallTotal  = 0;
    int      flushTotal  = 0;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns an all-quiet input vector with reset released.
    function automatic stim_t idleStim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Drives one cycle of inputs just after the rising edge, then records
    // what the hazard rules say the outputs must be for that cycle.
    task automatic applyStimulus(input stim_t s);
        expect_t e;
        bit      frozen;
        bit      loadUse;
        logic [4:0] idx;
        @(posedge clk);
        #1;
        reset               = s.rst;
        bus.id_src_idx      = s.id_src_idx;
        bus.id_src_used     = s.id_src_used;
        bus.ex_src_idx      = s.ex_src_idx;
        bus.ex_rd           = s.ex_rd;
        bus.ex_mem_read     = s.ex_mem_read;
        bus.ex_branch_taken = s.br;
        bus.mem_rd          = s.mem_rd;
        bus.mem_reg_write   = s.mem_rw;
        bus.mem_access      = s.mem_acc;
        bus.wb_rd           = s.wb_rd;
        bus.wb_reg_write    = s.wb_rw;

        cycleNum++;
        e       = '0;
        e.cycle = cycleNum;
        if (s.rst) begin
            accessAge  = -1;
            stallTotal = 0;
            flushTotal = 0;
        end else begin
            // An access is frozen for its first LAT cycles in MEM and moves
            // on in cycle LAT+1.
            if (accessAge < 0 && s.mem_acc) accessAge = 0;
            frozen = (accessAge >= 0) && (accessAge < LAT);

            for (int k = 0; k < NUM_SRC; k++) begin
                idx = s.ex_src_idx[k*5 +: 5];
                if (idx == 0)                         e.fwd[2*k +: 2] = 2'b00;
                else if (s.mem_rw && s.mem_rd == idx) e.fwd[2*k +: 2] = 2'b10;
                else if (s.wb_rw && s.wb_rd == idx)   e.fwd[2*k +: 2] = 2'b01;
                else                                  e.fwd[2*k +: 2] = 2'b00;
            end

            loadUse = 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
                if (s.ex_mem_read && s.ex_rd != 0 && s.id_src_used[k] &&
                    s.id_src_idx[k*5 +: 5] == s.ex_rd) loadUse = 1'b1;
            end

            if (frozen)        e.ctrl = 7'b0000001;
            else if (s.br)     e.ctrl = 7'b1111110;
            else if (loadUse)  e.ctrl = 7'b0001110;
            else               e.ctrl = 7'b1101010;

            e.stall = 4'(stallTotal > CNT_SAT ? CNT_SAT : stallTotal);
            e.flush = 4'(flushTotal > CNT_SAT ? CNT_SAT : flushTotal);

            if (e.ctrl[6] == 1'b0) stallTotal++;
            if (s.br && !frozen)   flushTotal++;
            if (accessAge >= 0) accessAge = (accessAge == LAT) ? -1 : accessAge + 1;
        end
        sbQ.push_back(e);
    endtask

    // Compares everything the design presents in one cycle with the
    // scoreboard entry for that cycle.
    task automatic checkOutput(input expect_t e);
        logic [6:0] ctrlAct;
        ctrlAct = {bus.pc_write_en, bus.if_id_write_en, bus.if_id_flush,
                   bus.id_ex_write_en, bus.id_ex_flush, bus.ex_mem_write_en,
                   bus.mem_wb_bubble};
        testsRun++;
        if (bus.fwd_sel !== e.fwd) begin
            testsFailed++;
            $display("[TB] FAIL fwd_sel cycle %0d: got %b expected %b", e.cycle, bus.fwd_sel, e.fwd);
        end
        testsRun++;
        if (ctrlAct !== e.ctrl) begin
            testsFailed++;
            $display("[TB] FAIL ctrl cycle %0d: got %b expected %b", e.cycle, ctrlAct, e.ctrl);
        end
        testsRun++;
        if (bus.stall_cycles !== e.stall) begin
            testsFailed++;
            $display("[TB] FAIL stall_cycles cycle %0d: got %0d expected %0d", e.cycle, bus.stall_cycles, e.stall);
        end
        testsRun++;
        if (bus.flush_count !== e.flush) begin
            testsFailed++;
            $display("[TB] FAIL flush_count cycle %0d: got %0d expected %0d", e.cycle, bus.flush_count, e.flush);
        end
    endtask

    // Monitor: on every falling edge, take the oldest expectation and check it.
    always @(negedge clk) begin
        if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
    end

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios first, then a randomized run.
    initial begin
        stim_t s;
        reset = 1'b1;
        bus.id_src_idx = '0; bus.id_src_used = '0; bus.ex_src_idx = '0;
        bus.ex_rd = '0; bus.ex_mem_read = 1'b0; bus.ex_branch_taken = 1'b0;
        bus.mem_rd = '0; bus.mem_reg_write = 1'b0; bus.mem_access = 1'b0;
        bus.wb_rd = '0; bus.wb_reg_write = 1'b0;

        // Reset state.
        s = idleStim(); s.rst = 1'b1;
        applyStimulus(s); applyStimulus(s);
        s = idleStim(); applyStimulus(s);

        // Forwarding: MEM over WB, then WB alone, then x0.
        s.ex_src_idx = {5'd5, 5'd5}; s.mem_rd = 5'd5; s.mem_rw = 1'b1;
        s.wb_rd = 5'd5; s.wb_rw = 1'b1;
        applyStimulus(s);
        s.mem_rw = 1'b0; applyStimulus(s);
        s.ex_src_idx = '0; applyStimulus(s);

        // Load-use on operand 1, then the same registers with no operand used.
        s = idleStim(); s.ex_mem_read = 1'b1; s.ex_rd = 5'd7;
        s.id_src_idx = {5'd7, 5'd0}; s.id_src_used = 2'b10;
        applyStimulus(s);
        s.id_src_used = 2'b00; applyStimulus(s);

        // Branch and load-use together, right after reset.
        s = idleStim(); s.rst = 1'b1; applyStimulus(s);
        s = idleStim(); s.ex_mem_read = 1'b1; s.ex_rd = 5'd7;
        s.id_src_idx = {5'd7, 5'd0}; s.id_src_used = 2'b10; s.br = 1'b1;
        applyStimulus(s);
        s = idleStim(); applyStimulus(s);

        // mem_access held high: two back-to-back freezes.
        s = idleStim(); s.mem_acc = 1'b1;
        repeat (8) applyStimulus(s);
        s = idleStim(); applyStimulus(s);

        // Taken branch held through a freeze: flush only on the release cycle.
        s = idleStim(); s.mem_acc = 1'b1; s.br = 1'b1; applyStimulus(s);
        s.mem_acc = 1'b0; repeat (3) applyStimulus(s);
        s = idleStim(); applyStimulus(s);

        // Reset in the second WAIT cycle, then a fresh freeze.
        s = idleStim(); s.mem_acc = 1'b1;
        applyStimulus(s); applyStimulus(s);
        s.rst = 1'b1; applyStimulus(s);
        s.rst = 1'b0; repeat (4) applyStimulus(s);
        s = idleStim(); applyStimulus(s);

        // Sixteen separate load-use stalls against a 4-bit counter.
        s = idleStim(); s.rst = 1'b1; applyStimulus(s);
        repeat (16) begin
            s = idleStim(); s.ex_mem_read = 1'b1; s.ex_rd = 5'd3;
            s.id_src_idx = {5'd0, 5'd3}; s.id_src_used = 2'b01;
            applyStimulus(s);
            s = idleStim(); applyStimulus(s);
        end

        // Randomized traffic with a small register range so hazards are common.
        s = idleStim(); s.rst = 1'b1; applyStimulus(s);
        repeat (400) begin
            s = idleStim();
            s.rst         = ($urandom_range(0, 49) == 0);
            s.id_src_idx  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            s.id_src_used = 2'($urandom_range(0, 3));
            s.ex_src_idx  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            s.ex_rd       = 5'($urandom_range(0, 7));
            s.ex_mem_read = ($urandom_range(0, 2) == 0);
            s.br          = ($urandom_range(0, 5) == 0);
            s.mem_rd      = 5'($urandom_range(0, 7));
            s.mem_rw      = 1'($urandom_range(0, 1));
            s.mem_acc     = ($urandom_range(0, 4) == 0);
            s.wb_rd       = 5'($urandom_range(0, 7));
            s.wb_rw       = 1'($urandom_range(0, 1));
            applyStimulus(s);
        end

        // Let the monitor drain the queue, then confirm nothing was left over.
        @(negedge clk);
        @(negedge clk);
        #1;
        testsRun++;
        if (sbQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
